// File: rtl/alu_pkg.sv
// Shared encodings and widths for the ALU front-end controller.
package alu_pkg;

    localparam int unsigned OPW  = 4;
    localparam int unsigned RESW = 8;

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_EXEC = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    localparam logic [1:0] CMD_ADD = 2'b00;
    localparam logic [1:0] CMD_SUB = 2'b01;
    localparam logic [1:0] CMD_MUL = 2'b10;
    localparam logic [1:0] CMD_DIV = 2'b11;

endpackage

// File: rtl/alu_sequencer_if.sv
// Operand entry and result bus between the switch/button front panel and the sequencer.
interface alu_sequencer_if;
    import alu_pkg::*;

    logic [OPW-1:0]  data_in;
    logic [1:0]      cmd_in;
    logic            enter;
    logic [RESW-1:0] result;
    logic            result_valid;
    logic            div_zero;
    logic [1:0]      state;

    modport master (
        output data_in, cmd_in, enter,
        input  result, result_valid, div_zero, state
    );

    modport slave (
        input  data_in, cmd_in, enter,
        output result, result_valid, div_zero, state
    );

endinterface

// File: rtl/alu_sequencer_alu.sv
// MyALU: combinational 4-bit ALU with 8-bit zero-extended result.
module MyALU
    import alu_pkg::*;
(
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  b,
    input  logic [1:0]      cmd,
    output logic [RESW-1:0] y
);

    logic [RESW-1:0] ae;
    logic [RESW-1:0] be;

    assign ae = RESW'(a);
    assign be = RESW'(b);

    always_comb begin
        y = '0;
        unique case (cmd)
            CMD_ADD: y = ae + be;
            CMD_SUB: y = ae - be;
            CMD_MUL: y = ae * be;
            // Guarded so the divider never yields X even before the top-level override.
            CMD_DIV: y = (b == '0) ? '0 : ae / be;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Operand/command entry sequencer around MyALU: edge-detected enter, registered result,
// valid and divide-by-zero flags, optional automatic timeout back to operand-A entry.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus
);

    localparam int unsigned CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    state_t          state_q, state_d;
    logic [OPW-1:0]  a_q, a_d;
    logic [OPW-1:0]  b_q, b_d;
    logic [1:0]      cmd_q, cmd_d;
    logic [RESW-1:0] result_q, result_d;
    logic            valid_q, valid_d;
    logic            dz_q, dz_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            enter_q;

    logic            ev;
    logic            exec_dz;
    logic [RESW-1:0] alu_y;

    assign ev      = bus.enter & ~enter_q;
    assign exec_dz = (cmd_q == CMD_DIV) && (b_q == '0);

    MyALU u_alu (
        .a   (a_q),
        .b   (b_q),
        .cmd (cmd_q),
        .y   (alu_y)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cmd_d    = cmd_q;
        result_d = result_q;
        valid_d  = valid_q;
        dz_d     = dz_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_A: begin
                if (ev) begin
                    a_d     = bus.data_in;
                    cnt_d   = '0;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (ev) begin
                    b_d     = bus.data_in;
                    cmd_d   = bus.cmd_in;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Presses here are dropped; enter_q still tracks so no stale edge survives.
                result_d = exec_dz ? '0 : alu_y;
                dz_d     = exec_dz;
                valid_d  = 1'b1;
                cnt_d    = '0;
                state_d  = S_SHOW;
            end
            S_SHOW: begin
                if (ev) begin
                    a_d     = bus.data_in;
                    valid_d = 1'b0;
                    dz_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_B;
                end else if (HOLD_CYCLES > 0 && cnt_q == HOLD_LAST) begin
                    valid_d = 1'b0;
                    dz_d    = 1'b0;
                    state_d = S_A;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_A;
            a_q      <= '0;
            b_q      <= '0;
            cmd_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
            enter_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cmd_q    <= cmd_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            dz_q     <= dz_d;
            cnt_q    <= cnt_d;
            enter_q  <= bus.enter;
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.div_zero     = dz_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: one instance holds results indefinitely, one times out.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] data_in = '0;
    logic [1:0] cmd_in = '0;
    logic       enter = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer_if if0 ();
    alu_sequencer_if if1 ();

    assign if0.data_in = data_in;
    assign if0.cmd_in  = cmd_in;
    assign if0.enter   = enter;
    assign if1.data_in = data_in;
    assign if1.cmd_in  = cmd_in;
    assign if1.enter   = enter;

    alu_sequencer #(.HOLD_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    alu_sequencer #(.HOLD_CYCLES(5)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    typedef struct packed {
        logic [7:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rising result_valid on dut0 must match the oldest queued expectation.
    always @(negedge clk) begin
        if (if0.result_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(if0.result), 32'hdead);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 32'(if0.result), 32'(e.r));
                check("div_zero", 32'(if0.div_zero), 32'(e.dz));
                check("no_x", 32'($isunknown({if0.result, if0.div_zero, if0.state})), 32'd0);
            end
        end
        prev_valid <= if0.result_valid;
    end

    task automatic press(input logic [3:0] d, input logic [1:0] c, input int hold);
        @(negedge clk);
        data_in = d;
        cmd_in  = c;
        enter   = 1'b1;
        repeat (hold) @(negedge clk);
        enter = 1'b0;
    endtask

    // A press, B press; checks the 2-edge latency from B event to valid result.
    task automatic op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] c,
                      input logic [7:0] r, input logic dz);
        exp_t e;
        press(a, 2'b00, 1);
        check("state_after_a", 32'(if0.state), 32'(S_B));
        check("state_after_a_t", 32'(if1.state), 32'(S_B));
        check("valid_drop", 32'(if0.result_valid), 32'd0);
        e.r  = r;
        e.dz = dz;
        sb.push_back(e);
        press(b, c, 1);
        check("state_exec", 32'(if0.state), 32'(S_EXEC));
        check("valid_exec", 32'(if0.result_valid), 32'd0);
        @(negedge clk);
        check("valid_show", 32'(if0.result_valid), 32'd1);
        check("state_show", 32'(if0.state), 32'(S_SHOW));
    endtask

    initial begin
        int transitions;
        logic [1:0] last_state;
        bit reached;
        exp_t e;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_state", 32'(if0.state), 32'(S_A));
        check("rst_result", 32'(if0.result), 32'h00);
        check("rst_valid", 32'(if0.result_valid), 32'd0);
        check("rst_dz", 32'(if0.div_zero), 32'd0);

        op(4'd7, 4'd9, CMD_ADD, 8'h10, 1'b0);
        op(4'd3, 4'd5, CMD_SUB, 8'hFE, 1'b0);
        op(4'd15, 4'd15, CMD_MUL, 8'hE1, 1'b0);
        op(4'd13, 4'd4, CMD_DIV, 8'h03, 1'b0);
        op(4'd9, 4'd0, CMD_DIV, 8'h00, 1'b1);
        check("dz_out", 32'(if0.div_zero), 32'd1);

        // Chain: A=6 pressed from S_SHOW, then B=2 add.
        op(4'd6, 4'd2, CMD_ADD, 8'h08, 1'b0);

        // Timeout: dut1 entered S_SHOW at the last edge; dut0 keeps holding.
        repeat (4) @(negedge clk);
        check("hold_still_show", 32'(if1.state), 32'(S_SHOW));
        @(negedge clk);
        check("timeout_state", 32'(if1.state), 32'(S_A));
        check("timeout_valid", 32'(if1.result_valid), 32'd0);
        check("hold0_state", 32'(if0.state), 32'(S_SHOW));
        check("hold0_valid", 32'(if0.result_valid), 32'd1);

        // Enter held for 10 cycles in S_A yields exactly one event.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        transitions = 0;
        last_state = if0.state;
        data_in = 4'd5;
        enter = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if0.state != last_state) transitions++;
            last_state = if0.state;
        end
        enter = 1'b0;
        check("edge_transitions", 32'(transitions), 32'd1);
        check("edge_state", 32'(if0.state), 32'(S_B));

        // B press held through S_EXEC and S_SHOW: no extra event.
        e.r = 8'h08;
        e.dz = 1'b0;
        sb.push_back(e);
        press(4'd3, CMD_ADD, 4);
        check("held_b_state", 32'(if0.state), 32'(S_SHOW));
        check("held_b_valid", 32'(if0.result_valid), 32'd1);

        // Reset in S_B after A=12.
        press(4'd12, 2'b00, 1);
        check("pre_rst_state", 32'(if0.state), 32'(S_B));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_state", 32'(if0.state), 32'(S_A));
        check("mid_rst_result", 32'(if0.result), 32'h00);
        check("mid_rst_valid", 32'(if0.result_valid), 32'd0);
        op(4'd2, 4'd3, CMD_ADD, 8'h05, 1'b0);

        // Reset coinciding with an event: event lost, held enter re-fires after reset.
        @(negedge clk);
        rst = 1'b1;
        data_in = 4'd1;
        enter = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_evt_state", 32'(if0.state), 32'(S_A));
        check("rst_evt_result", 32'(if0.result), 32'h00);
        @(negedge clk);
        enter = 1'b0;
        check("refire_state", 32'(if0.state), 32'(S_B));
        e.r = 8'h05;
        e.dz = 1'b0;
        sb.push_back(e);
        press(4'd4, CMD_ADD, 1);
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            @(negedge clk);
            if (if0.result_valid) reached = 1'b1;
        end
        check("refire_done", 32'(reached), 32'd1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
